// File: rtl/hazard_scoreboard.sv
// Pipeline register scoreboard. It tracks the destinations in flight after decode and
// resolves decode-stage source operands into bypass selects or hazard stalls.
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int WB_WT = 0,
  parameter int SELW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue,
  input  logic [4:0]      issue_rd,
  input  logic            issue_wen,
  input  logic [2:0]      issue_lat,
  input  logic [4:0]      rs1_d,
  input  logic [4:0]      rs2_d,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] rs1_sel,
  output logic [SELW-1:0] rs2_sel,
  output logic [31:0]     stall_cnt
);

  // Slot k holds the instruction that is k stages past decode (1=E ... DEPTH=W).
  logic [DEPTH:1]      vld_q, vld_d;
  logic [DEPTH:1][4:0] rd_q, rd_d;
  logic [DEPTH:1][2:0] lat_q, lat_d;
  logic [31:0]         cnt_q, cnt_d;

  logic            adv;
  logic            stall_rs1, stall_rs2;
  logic [SELW-1:0] sel1, sel2;

  function automatic logic [2:0] clamp_lat(input logic [2:0] l);
    if (l < 3'd2) return 3'd2;
    if (int'(l) > DEPTH) return 3'(DEPTH);
    return l;
  endfunction

  // Returns {stall, sel}. Only the youngest matching slot decides the outcome.
  function automatic logic [SELW:0] resolve(
    input logic [4:0]          rs,
    input logic                used,
    input logic [DEPTH:1]      v,
    input logic [DEPTH:1][4:0] rds,
    input logic [DEPTH:1][2:0] lats
  );
    logic            hit;
    logic            st;
    logic [SELW-1:0] sel;
    hit = 1'b0;
    st  = 1'b0;
    sel = '0;
    if (used && (rs != 5'd0)) begin
      for (int k = 1; k <= DEPTH; k++) begin
        if (!hit && v[k] && (rds[k] == rs)) begin
          hit = 1'b1;
          if (k < DEPTH) begin
            // Next cycle this producer sits in stage k+1; bypass only once its result exists there.
            if ((k + 1) >= int'(lats[k])) sel = SELW'(k + 1);
            else st = 1'b1;
          end else if (WB_WT == 0) begin
            st = 1'b1;
          end
        end
      end
    end
    return {st, sel};
  endfunction

  always_comb begin
    {stall_rs1, sel1} = resolve(rs1_d, rs1_used, vld_q, rd_q, lat_q);
    {stall_rs2, sel2} = resolve(rs2_d, rs2_used, vld_q, rd_q, lat_q);
    stall   = stall_rs1 | stall_rs2 | reset;
    rs1_sel = stall ? '0 : sel1;
    rs2_sel = stall ? '0 : sel2;
    adv     = issue & ~stall & ~flush;
  end

  always_comb begin
    vld_d    = '0;
    rd_d     = rd_q;
    lat_d    = lat_q;
    vld_d[1] = adv & issue_wen & (issue_rd != 5'd0);
    rd_d[1]  = issue_rd;
    lat_d[1] = clamp_lat(issue_lat);
    for (int k = 2; k <= DEPTH; k++) begin
      vld_d[k] = vld_q[k-1];
      rd_d[k]  = rd_q[k-1];
      lat_d[k] = lat_q[k-1];
    end
    // A flushed slot-1 entry must not reappear in slot 2.
    vld_d[2] = vld_q[1] & ~flush;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    lat_q <= lat_d;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard at DEPTH=3, with one instance per write-through setting.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue;
  logic [4:0]  issue_rd;
  logic        issue_wen;
  logic [2:0]  issue_lat;
  logic [4:0]  rs1_d, rs2_d;
  logic        rs1_used, rs2_used;
  logic        flush;

  logic        stall, stall_w;
  logic [2:0]  rs1_sel, rs2_sel, rs1_sel_w, rs2_sel_w;
  logic [31:0] stall_cnt, stall_cnt_w;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .WB_WT(0), .SELW(3)) dut (
    .clk(clk), .reset(reset), .issue(issue), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_lat(issue_lat), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .flush(flush), .stall(stall), .rs1_sel(rs1_sel),
    .rs2_sel(rs2_sel), .stall_cnt(stall_cnt)
  );

  hazard_scoreboard #(.DEPTH(3), .WB_WT(1), .SELW(3)) dut_wt (
    .clk(clk), .reset(reset), .issue(issue), .issue_rd(issue_rd), .issue_wen(issue_wen),
    .issue_lat(issue_lat), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_used(rs1_used),
    .rs2_used(rs2_used), .flush(flush), .stall(stall_w), .rs1_sel(rs1_sel_w),
    .rs2_sel(rs2_sel_w), .stall_cnt(stall_cnt_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue = 1'b0; issue_rd = 5'd0; issue_wen = 1'b0; issue_lat = 3'd2;
    rs1_d = 5'd0; rs2_d = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0; flush = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [2:0] lat);
    issue = 1'b1; issue_rd = rd; issue_wen = 1'b1; issue_lat = lat;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || rs1_sel !== 3'd0 || rs2_sel !== 3'd0) begin
      errs++; $display("FAIL reset_outputs: got stall=%0b sel=%0d/%0d want 1 0/0", stall, rs1_sel, rs2_sel);
    end
    repeat (2) tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || stall_cnt !== 32'd0 || stall_w !== 1'b0 || stall_cnt_w !== 32'd0) begin
      errs++; $display("FAIL reset_release: got stall=%0b cnt=%0d stall_w=%0b cnt_w=%0d want 0 0 0 0",
                       stall, stall_cnt, stall_w, stall_cnt_w);
    end
  endtask

  task automatic test_alu_bypass();
    do_issue(5'd5, 3'd2);
    tick();
    idle();
    rs1_d = 5'd5; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd2) begin
      errs++; $display("FAIL alu_bypass: got stall=%0b rs1_sel=%0d want 0 2", stall, rs1_sel);
    end
    drain();
  endtask

  task automatic test_load_use();
    do_issue(5'd6, 3'd3);
    tick();
    do_issue(5'd12, 3'd2);
    issue_wen = 1'b0;
    rs2_d = 5'd6; rs2_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || rs2_sel !== 3'd0) begin
      errs++; $display("FAIL load_use_stall: got stall=%0b rs2_sel=%0d want 1 0", stall, rs2_sel);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || rs2_sel !== 3'd3) begin
      errs++; $display("FAIL load_use_bypass: got stall=%0b rs2_sel=%0d want 0 3", stall, rs2_sel);
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      errs++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt);
    end
    drain();
  endtask

  task automatic test_writeback();
    do_issue(5'd7, 3'd2);
    tick();
    idle();
    repeat (2) tick();
    rs1_d = 5'd7; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || rs1_sel !== 3'd0) begin
      errs++; $display("FAIL wb_nowt_stall: got stall=%0b rs1_sel=%0d want 1 0", stall, rs1_sel);
    end
    checks++;
    if (stall_w !== 1'b0 || rs1_sel_w !== 3'd0) begin
      errs++; $display("FAIL wb_wt: got stall=%0b rs1_sel=%0d want 0 0", stall_w, rs1_sel_w);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd0 || stall_cnt !== 32'd2) begin
      errs++; $display("FAIL wb_nowt_after: got stall=%0b rs1_sel=%0d cnt=%0d want 0 0 2", stall, rs1_sel, stall_cnt);
    end
    drain();
  endtask

  task automatic test_youngest();
    do_issue(5'd8, 3'd2);
    tick();
    do_issue(5'd8, 3'd2);
    tick();
    idle();
    rs1_d = 5'd8; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd2) begin
      errs++; $display("FAIL youngest: got stall=%0b rs1_sel=%0d want 0 2", stall, rs1_sel);
    end
    do_issue(5'd0, 3'd2);
    rs1_d = 5'd0; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd0) begin
      errs++; $display("FAIL x0_source: got stall=%0b rs1_sel=%0d want 0 0", stall, rs1_sel);
    end
    drain();
  endtask

  task automatic test_flush();
    do_issue(5'd9, 3'd3);
    tick();
    do_issue(5'd10, 3'd2);
    flush = 1'b1;
    tick();
    idle();
    rs1_d = 5'd9; rs1_used = 1'b1;
    rs2_d = 5'd10; rs2_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd0) begin
      errs++; $display("FAIL flush_slot2: got stall=%0b rs1_sel=%0d want 0 0", stall, rs1_sel);
    end
    checks++;
    if (rs2_sel !== 3'd0) begin
      errs++; $display("FAIL flush_noload: got rs2_sel=%0d want 0", rs2_sel);
    end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    do_issue(5'd11, 3'd3);
    tick();
    idle();
    rs1_d = 5'd11; rs1_used = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || stall_cnt !== 32'd2 || stall_cnt_w !== 32'd1) begin
      errs++; $display("FAIL mid_pre: got stall=%0b cnt=%0d cnt_w=%0d want 1 2 1", stall, stall_cnt, stall_cnt_w);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1 || rs1_sel !== 3'd0 || rs2_sel !== 3'd0) begin
      errs++; $display("FAIL mid_reset: got stall=%0b sel=%0d/%0d want 1 0/0", stall, rs1_sel, rs2_sel);
    end
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0 || rs1_sel !== 3'd0 || stall_cnt !== 32'd0 || stall_cnt_w !== 32'd0) begin
      errs++; $display("FAIL mid_after: got stall=%0b rs1_sel=%0d cnt=%0d cnt_w=%0d want 0 0 0 0",
                       stall, rs1_sel, stall_cnt, stall_cnt_w);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_bypass();
    test_load_use();
    test_writeback();
    test_youngest();
    test_flush();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning the number of tracked post-decode stages (1=E, 2=M, 3=W), legal range 2..7.
REQ-002 SHALL have parameter WB_WT, default 0, meaning 1 = register file writes through to same-cycle decode reads, 0 = no write-through.
REQ-003 SHALL have parameter SELW, default 3, meaning bypass-select width, at least clog2(DEPTH+1).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-006 SHALL have port issue, input, 1, meaning a valid instruction is in D and wants to advance to E.
REQ-007 SHALL have port issue_rd, input, 5, meaning the destination of the D instruction.
REQ-008 SHALL have port issue_wen, input, 1, meaning the D instruction writes issue_rd.
REQ-009 SHALL have port issue_lat, input, 3, meaning the first stage index from which the D result is bypassable (ALU=2, load/JAL/JALR=3).
REQ-010 SHALL have ports rs1_d and rs2_d, input, 5 each, meaning the D source registers.
REQ-011 SHALL have ports rs1_used and rs2_used, input, 1 each, meaning the source is actually read.
REQ-012 SHALL have port flush, input, 1, meaning kill the D instruction and the slot-1 entry.
REQ-013 SHALL have port stall, output, 1, meaning hold fetch/decode.
REQ-014 SHALL have ports rs1_sel and rs2_sel, output, SELW each, meaning operand source for E next cycle (0=regfile, k=bypass from stage k).
REQ-015 SHALL have port stall_cnt, output, 32, meaning the saturating count of hazard-stall cycles.

Function
REQ-016 SHALL hold DEPTH slots; each slot holds valid, rd[4:0], lat[2:0].
REQ-017 Each cycle, SHALL shift slot k into slot k+1 for k<DEPTH; slot DEPTH content retires (written to regfile that cycle).
REQ-018 SHALL define adv = issue & ~stall & ~flush; slot 1 loads {issue_wen & (issue_rd!=0), issue_rd, clamp(issue_lat,2,DEPTH)} when adv, else a bubble (valid=0).
REQ-019 flush SHALL clear slot 1 before the shift (no slot-2 entry from it next cycle) and suppress the load; other slots are unaffected.
REQ-020 Per used source rs!=0, SHALL search valid slots with rd==rs; the youngest match (lowest k) alone decides.
REQ-021 Match at k<DEPTH: if k+1 >= slot.lat, SHALL drive sel=k+1 and no stall from that source; otherwise SHALL assert that source's stall.
REQ-022 Match at k==DEPTH: WB_WT=1 -> sel=0, no stall; WB_WT=0 -> stall for 1 cycle, then sel=0.
REQ-023 No match, rs==0, or source unused: SHALL drive sel=0 with no stall from that source.
REQ-024 stall SHALL equal stall_rs1 | stall_rs2 | reset, purely combinational from current slots and D inputs (independent of issue).
REQ-025 While stall=1, sel outputs SHALL be 0.
REQ-026 stall_cnt SHALL increment by 1 each cycle that stall=1 with reset=0, saturating at 0xFFFFFFFF.

Reset
REQ-027 With reset=1 at a rising edge, SHALL clear all slot valid bits and stall_cnt to 0, regardless of issue/flush.
REQ-028 During reset, outputs SHALL be stall=1, rs1_sel=0, rs2_sel=0; the first post-reset cycle shows stall=0 with no valid slots.

Verification (DEPTH=3)
REQ-029 Issue ALU x5 (lat 2); next cycle rs1_d=5 used -> stall=0, rs1_sel=2.
REQ-030 Issue load x6 (lat 3); next cycle rs2_d=6 -> stall=1 for 1 cycle, then stall=0, rs2_sel=3; stall_cnt +1.
REQ-031 x7 in slot 3, rs1_d=7: WB_WT=0 -> stall 1 cycle then rs1_sel=0; WB_WT=1 -> stall=0, rs1_sel=0.
REQ-032 ALU x8 in slot 1 and slot 2, rs1_d=8 -> rs1_sel=2 (youngest wins); issue with rd=0 and rs1_d=0 -> rs1_sel=0, no stall.
REQ-033 Load x9 in slot 1 and flush=1 -> next cycle slot 2 holds no x9; rs1_d=9 -> stall=0, rs1_sel=0.
REQ-034 Assert reset mid-stall with slots valid -> stall=1 during reset; after release, all slots are empty and stall_cnt=0.
